// File: rtl/kbest_frame_sequencer.sv
// Frame sequencer for the 4x4 16QAM K-best detector core: beat strobes to the core,
// fixed-latency frame tracking and an output decision FIFO with frame credits.
module kbest_frame_sequencer #(
   parameter int IN_WL      = 15,
   parameter int BEATS      = 10,
   parameter int LATENCY    = 132,
   parameter int FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sof,
   input  logic [IN_WL-1:0] in_d0,
   input  logic [IN_WL-1:0] in_d1,
   input  logic [IN_WL-1:0] in_d2,
   input  logic [IN_WL-1:0] in_d3,
   output logic             core_we,
   output logic [3:0]       core_beat,
   output logic [IN_WL-1:0] core_d0,
   output logic [IN_WL-1:0] core_d1,
   output logic [IN_WL-1:0] core_d2,
   output logic [IN_WL-1:0] core_d3,
   input  logic [15:0]      core_x,
   output logic             x_valid,
   input  logic             x_ready,
   output logic [15:0]      x_data,
   output logic [7:0]       x_frame_id,
   output logic             err_framing,
   output logic             err_gap,
   output logic             busy
);
   localparam int TOK_D = LATENCY - (BEATS - 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t          state;
   logic [3:0]      beat;
   logic [TOK_D-1:0] tok_sr;
   logic [CW-1:0]   tok_cnt, fifo_cnt, tok_cnt_n, fifo_cnt_n;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      retire_cnt;
   logic [23:0]     fifo_mem [FIFO_DEPTH];

   logic accept, last_beat, emerge, pop, load_n, credit_n, write_beat;

   always_comb begin
      accept     = in_valid & in_ready;
      last_beat  = (state == LOAD) & in_valid & ~in_sof & (beat == 4'(BEATS - 1));
      emerge     = tok_sr[TOK_D-1];
      pop        = x_valid & x_ready;
      write_beat = accept & (in_sof | (state == LOAD));
      load_n     = (state == IDLE) ? (accept & in_sof) : (in_valid & ~last_beat);
      tok_cnt_n  = tok_cnt + CW'(last_beat) - CW'(emerge);
      fifo_cnt_n = fifo_cnt + CW'(emerge) - CW'(pop);
      // in_ready is registered, so the credit test looks at next-cycle occupancy
      credit_n   = ({1'b0, tok_cnt_n} + {1'b0, fifo_cnt_n}) < (CW+1)'(FIFO_DEPTH);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         beat        <= '0;
         in_ready    <= 1'b0;
         core_we     <= 1'b0;
         core_beat   <= '0;
         core_d0     <= '0;
         core_d1     <= '0;
         core_d2     <= '0;
         core_d3     <= '0;
         tok_sr      <= '0;
         tok_cnt     <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         retire_cnt  <= '0;
         err_framing <= 1'b0;
         err_gap     <= 1'b0;
      end else begin
         core_we <= write_beat;
         if (write_beat) begin
            core_beat <= in_sof ? 4'd0 : beat;
            core_d0   <= in_d0;
            core_d1   <= in_d1;
            core_d2   <= in_d2;
            core_d3   <= in_d3;
         end
         in_ready <= load_n | credit_n;
         tok_sr   <= {tok_sr[TOK_D-2:0], last_beat};
         tok_cnt  <= tok_cnt_n;
         fifo_cnt <= fifo_cnt_n;
         if (emerge) begin
            wr_ptr     <= wr_ptr + 1'b1;
            retire_cnt <= retire_cnt + 8'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_sof) begin
                     state <= LOAD;
                     beat  <= 4'd1;
                  end else begin
                     err_framing <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (!in_valid) begin
                  err_gap <= 1'b1;
                  state   <= IDLE;
                  beat    <= '0;
               end else if (in_sof) begin
                  err_framing <= 1'b1;
                  beat        <= 4'd1;
               end else if (last_beat) begin
                  state <= IDLE;
                  beat  <= '0;
               end else begin
                  beat <= beat + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (emerge)
         fifo_mem[wr_ptr] <= {core_x, retire_cnt};
   end

   assign x_valid    = (fifo_cnt != '0);
   assign x_data     = x_valid ? fifo_mem[rd_ptr][23:8] : '0;
   assign x_frame_id = x_valid ? fifo_mem[rd_ptr][7:0] : '0;
   assign busy       = (state == LOAD) | (tok_cnt != '0);

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(emerge && !pop && fifo_cnt == CW'(FIFO_DEPTH)));
endmodule

// File: tb/tb_kbest_frame_sequencer.sv
// Scoreboard bench for kbest_frame_sequencer: stimulus pushes expected {data,id} per
// completed frame; a negedge monitor pops and compares whenever the FIFO head is consumed.
module tb_kbest_frame_sequencer;
   localparam int IN_WL      = 15;
   localparam int BEATS      = 10;
   localparam int LATENCY    = 132;
   localparam int FIFO_DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic in_valid = 1'b0, in_sof = 1'b0, in_ready;
   logic [IN_WL-1:0] in_d0 = '0, in_d1 = '0, in_d2 = '0, in_d3 = '0;
   logic core_we;
   logic [3:0] core_beat;
   logic [IN_WL-1:0] core_d0, core_d1, core_d2, core_d3;
   logic [15:0] core_x;
   logic x_valid, x_ready = 1'b0;
   logic [15:0] x_data;
   logic [7:0] x_frame_id;
   logic err_framing, err_gap, busy;

   int   cyc = 0;
   int   checks = 0, failures = 0;
   int   last_c0 = 0;
   logic [7:0] exp_id = '0;
   bit   xr_val = 1'b0, rand_ready = 1'b0;

   typedef struct { logic [15:0] d; logic [7:0] id; } exp_t;
   exp_t q[$];

   kbest_frame_sequencer #(.IN_WL(IN_WL), .BEATS(BEATS), .LATENCY(LATENCY),
                           .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_d3(in_d3),
      .core_we(core_we), .core_beat(core_beat),
      .core_d0(core_d0), .core_d1(core_d1), .core_d2(core_d2), .core_d3(core_d3),
      .core_x(core_x), .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
      .x_frame_id(x_frame_id), .err_framing(err_framing), .err_gap(err_gap), .busy(busy));

   // Detector core stand-in: its decision output is a known function of the cycle number
   function automatic logic [15:0] core_model(input int c);
      return 16'(c * 40503) ^ 16'h5a5a;
   endfunction

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign core_x = core_model(cyc);

   always begin
      @(posedge clk);
      #2;
      x_ready = rand_ready ? 1'($urandom_range(0, 1)) : xr_val;
   end

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: head stability under backpressure, and in-order scoreboard compare on pop
   bit         held = 1'b0;
   logic [23:0] hold_d = '0;
   always @(negedge clk) begin
      if (!rst) begin
         held = 1'b0;
      end else begin
         if (held) check("x_hold_stable", {x_valid, x_data, x_frame_id}, {1'b1, hold_d});
         held   = x_valid & ~x_ready;
         hold_d = {x_data, x_frame_id};
         if (x_valid && x_ready) begin
            if (q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL x_unexpected actual=data %0h id %0d required=no output", x_data, x_frame_id);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("x_data", x_data, e.d);
               check("x_frame_id", x_frame_id, e.id);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int nbeats, input bit chk_wait0);
      int waits = 0;
      int c0 = 0;
      logic [IN_WL-1:0] w0, w1, w2, w3;
      for (int k = 0; k < nbeats; k++) begin
         w0 = IN_WL'($urandom); w1 = IN_WL'($urandom);
         w2 = IN_WL'($urandom); w3 = IN_WL'($urandom);
         in_valid = 1'b1; in_sof = (k == 0);
         in_d0 = w0; in_d1 = w1; in_d2 = w2; in_d3 = w3;
         if (k == 0) begin
            while (!in_ready && waits < 400) begin
               step();
               waits++;
            end
            if (!in_ready) begin
               check("accept_timeout", in_ready, 1'b1);
               in_valid = 1'b0; in_sof = 1'b0;
               return;
            end
            c0 = cyc;
         end
         step();
         check("core_write", {core_we, core_beat, core_d0, core_d1, core_d2, core_d3},
               {1'b1, 4'(k), w0, w1, w2, w3});
      end
      in_valid = 1'b0; in_sof = 1'b0;
      if (chk_wait0) check("in_ready_wait", waits, 0);
      if (nbeats == BEATS) begin
         q.push_back('{d: core_model(c0 + LATENCY), id: exp_id});
         exp_id++;
         last_c0 = c0;
      end
   endtask

   task automatic drain();
      int t = 0;
      while ((q.size() != 0 || x_valid) && t < 1000) begin
         step();
         t++;
      end
      check("drain_empty", q.size(), 0);
   endtask

   task automatic latency_check();
      int t = 0;
      while (!x_valid && t < 400) begin
         step();
         t++;
      end
      check("x_valid_latency", cyc, last_c0 + LATENCY + 1);
   endtask

   task automatic check_reset_outputs(input string name);
      check(name, {in_ready, x_valid, core_we, busy, err_framing, err_gap, core_beat,
                   x_data, x_frame_id}, '0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int blocked;
      int seen;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset_outputs");
      @(posedge clk); #1;
      rst = 1'b1;
      step();

      // single frame: beat timing and x_valid latency
      xr_val = 1'b1;
      send_frame(BEATS, 1'b1);
      latency_check();
      drain();

      // 500 back-to-back frames, ids wrap
      for (int f = 0; f < 500; f++) send_frame(BEATS, 1'b1);
      drain();
      check("err_after_b2b", {err_framing, err_gap}, 2'b00);

      // random consumer backpressure and random idle gaps
      rand_ready = 1'b1;
      for (int f = 0; f < 30; f++) begin
         send_frame(BEATS, 1'b0);
         repeat ($urandom_range(0, 5)) step();
      end
      rand_ready = 1'b0;
      xr_val = 1'b1;
      drain();

      // credit limit with stalled consumer
      xr_val = 1'b0;
      step();
      for (int f = 0; f < FIFO_DEPTH; f++) send_frame(BEATS, 1'b1);
      in_valid = 1'b1; in_sof = 1'b1;
      blocked = 0;
      repeat (150) begin
         if (in_ready) blocked++;
         step();
      end
      in_valid = 1'b0; in_sof = 1'b0;
      check("credit_block", blocked, 0);
      check("fifo_full_valid", x_valid, 1'b1);
      xr_val = 1'b1;
      step();
      xr_val = 1'b0;
      step();
      send_frame(BEATS, 1'b1);
      in_valid = 1'b1; in_sof = 1'b1;
      blocked = 0;
      repeat (150) begin
         if (in_ready) blocked++;
         step();
      end
      in_valid = 1'b0; in_sof = 1'b0;
      check("credit_block_again", blocked, 0);
      xr_val = 1'b1;
      drain();

      // gap at beat 4
      send_frame(4, 1'b0);
      step();
      check("gap_no_write", core_we, 1'b0);
      check("err_gap_set", {err_gap, err_framing}, 2'b10);
      send_frame(BEATS, 1'b1);
      drain();

      // beat 0 without sof, then sof at beat 6
      in_valid = 1'b1; in_sof = 1'b0; in_d0 = IN_WL'($urandom);
      check("idle_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      check("nosof_dropped", core_we, 1'b0);
      check("err_framing_set", err_framing, 1'b1);
      send_frame(6, 1'b0);
      send_frame(BEATS, 1'b0);
      drain();

      // reset with frames in flight
      for (int f = 0; f < 3; f++) send_frame(BEATS, 1'b1);
      repeat (20) step();
      check("busy_inflight", busy, 1'b1);
      rst = 1'b0;
      q.delete();
      exp_id = '0;
      @(negedge clk);
      check_reset_outputs("midreset_outputs");
      step();
      rst = 1'b1;
      seen = 0;
      repeat (200) begin
         if (x_valid) seen++;
         step();
      end
      check("no_stale_output", seen, 0);
      send_frame(BEATS, 1'b1);
      latency_check();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
